// File: rtl/bus_pkg.sv
// Shared arbiter types: FSM state encoding and grant-index width helper.
package bus_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   function automatic int grant_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational winner select: first set request at or after 'start', wrapping.
module rr_picker #(
   parameter int N  = 2,
   parameter int GW = 1
) (
   input  logic [N-1:0]  req,
   input  logic [GW-1:0] start,
   output logic [N-1:0]  onehot,
   output logic [GW-1:0] idx,
   output logic          any
);

   logic [2*N-1:0] rot2;
   logic [2*N-1:0] back2;
   logic [N-1:0]   rot;
   logic [N-1:0]   rot_oh;
   int             first;
   int             sum;

   // Rotate so 'start' sits at bit 0, pick lowest, rotate the one-hot back.
   assign rot2   = {req, req} >> start;
   assign rot    = rot2[N-1:0];
   assign back2  = {rot_oh, rot_oh} << start;
   assign onehot = back2[2*N-1:N];

   always_comb begin
      rot_oh = '0;
      first  = 0;
      any    = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (rot[i] && !any) begin
            any       = 1'b1;
            rot_oh[i] = 1'b1;
            first     = i;
         end
      end
      sum = int'(start) + first;
      if (sum >= N) sum = sum - N;
      idx = GW'(sum);
   end

endmodule

// File: rtl/bus_arbiter.sv
// Multi-channel to single external bus arbiter, IDLE/BUSY FSM, 2-cycle minimum latency.
// Define BUS_ARBITER_ROUND_ROBIN_EN for round-robin; otherwise fixed priority (channel 0 highest).
module bus_arbiter
   import bus_pkg::*;
#(
   parameter int N_PORTS    = 2,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [N_PORTS-1:0]                req_valid,
   input  logic [N_PORTS*ADDR_WIDTH-1:0]     req_address,
   input  logic [N_PORTS*DATA_WIDTH-1:0]     req_write_data,
   input  logic [N_PORTS*DATA_WIDTH/8-1:0]   req_write_strobe,
   output logic [N_PORTS-1:0]                req_ready,
   output logic [DATA_WIDTH-1:0]             req_read_data,
   output logic                              ext_valid,
   output logic                              ext_instruction,
   input  logic                              ext_ready,
   output logic [ADDR_WIDTH-1:0]             ext_address,
   output logic [DATA_WIDTH-1:0]             ext_write_data,
   output logic [DATA_WIDTH/8-1:0]           ext_write_strobe,
   input  logic [DATA_WIDTH-1:0]             ext_read_data
);

   localparam int GW = grant_width(N_PORTS);
   localparam int SW = DATA_WIDTH / 8;

   arb_state_t          state;
   logic [N_PORTS-1:0]  grant_oh;
   logic [N_PORTS-1:0]  pick_onehot;
   logic [GW-1:0]       pick_idx;
   logic [GW-1:0]       start_ptr;
   logic                pick_any;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_data;
   logic [SW-1:0]         sel_strb;

   rr_picker #(
      .N  (N_PORTS),
      .GW (GW)
   ) u_picker (
      .req    (req_valid),
      .start  (start_ptr),
      .onehot (pick_onehot),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      sel_strb = '0;
      for (int i = 0; i < N_PORTS; i++) begin
         if (pick_onehot[i]) begin
            sel_addr = req_address[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_data = req_write_data[i*DATA_WIDTH +: DATA_WIDTH];
            sel_strb = req_write_strobe[i*SW +: SW];
         end
      end
   end

`ifdef BUS_ARBITER_ROUND_ROBIN_EN
   logic [GW-1:0] ptr;
   logic [GW-1:0] grant;

   assign start_ptr = ptr;

   // Pointer only advances on completion, so an aborted grant leaves it untouched.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr   <= '0;
         grant <= '0;
      end else if (state == IDLE && pick_any) begin
         grant <= pick_idx;
      end else if (state == BUSY && ext_ready) begin
         ptr <= (grant == GW'(N_PORTS - 1)) ? '0 : grant + 1'b1;
      end
   end
`else
   assign start_ptr = '0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state            <= IDLE;
         grant_oh         <= '0;
         ext_valid        <= 1'b0;
         ext_instruction  <= 1'b0;
         ext_address      <= '0;
         ext_write_data   <= '0;
         ext_write_strobe <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_any) begin
                  state            <= BUSY;
                  grant_oh         <= pick_onehot;
                  ext_valid        <= 1'b1;
                  ext_instruction  <= (pick_idx == '0);
                  ext_address      <= sel_addr;
                  ext_write_data   <= sel_data;
                  ext_write_strobe <= sel_strb;
               end
            end
            BUSY: begin
               if (ext_ready) begin
                  state     <= IDLE;
                  ext_valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign req_ready     = (state == BUSY && ext_ready) ? grant_oh : '0;
   assign req_read_data = ext_read_data;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter (N_PORTS=3) with a transaction-level reference model.
module tb_bus_arbiter;

   localparam int N  = 3;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    req_valid;
   logic [N*AW-1:0] req_address;
   logic [N*DW-1:0] req_write_data;
   logic [N*SW-1:0] req_write_strobe;
   logic [N-1:0]    req_ready;
   logic [DW-1:0]   req_read_data;
   logic            ext_valid;
   logic            ext_instruction;
   logic            ext_ready;
   logic [AW-1:0]   ext_address;
   logic [DW-1:0]   ext_write_data;
   logic [SW-1:0]   ext_write_strobe;
   logic [DW-1:0]   ext_read_data;

   int total = 0;
   int bad   = 0;

   bit            m_busy = 0;
   int            m_grant = 0;
   int            m_ptr = 0;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;
   logic [SW-1:0] m_strb;
   int            mlog[$];
   int            dlog[$];
   int            pulses = 0;
   int            exp_order[4];

   bus_arbiter #(
      .N_PORTS    (N),
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .req_valid        (req_valid),
      .req_address      (req_address),
      .req_write_data   (req_write_data),
      .req_write_strobe (req_write_strobe),
      .req_ready        (req_ready),
      .req_read_data    (req_read_data),
      .ext_valid        (ext_valid),
      .ext_instruction  (ext_instruction),
      .ext_ready        (ext_ready),
      .ext_address      (ext_address),
      .ext_write_data   (ext_write_data),
      .ext_write_strobe (ext_write_strobe),
      .ext_read_data    (ext_read_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // First requesting channel at or after the start position, wrapping around.
   function automatic int pick(input logic [N-1:0] v, input int p);
      for (int k = 0; k < N; k++) begin
         if (v[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   always @(posedge clk) begin
      if (!reset) begin
         m_busy = 0;
         m_ptr  = 0;
      end else if (!m_busy) begin
         if (req_valid != '0) begin
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
            m_grant = pick(req_valid, m_ptr);
`else
            m_grant = pick(req_valid, 0);
`endif
            m_busy = 1;
            m_addr = req_address[m_grant*AW +: AW];
            m_data = req_write_data[m_grant*DW +: DW];
            m_strb = req_write_strobe[m_grant*SW +: SW];
            mlog.push_back(m_grant);
         end
      end else if (ext_ready) begin
         m_busy = 0;
         m_ptr  = (m_grant + 1) % N;
      end
   end

   always @(negedge clk) begin
      logic [N-1:0] exp_ready;
      if (!reset) begin
         chk("rst_ext_valid", ext_valid, 0);
         chk("rst_req_ready", req_ready, 0);
         chk("rst_strobe", ext_write_strobe, 0);
         chk("rst_instr", ext_instruction, 0);
         chk("rst_addr", ext_address, 0);
         chk("rst_wdata", ext_write_data, 0);
      end else begin
         exp_ready = (m_busy && ext_ready) ? (N'(1) << m_grant) : '0;
         chk("ext_valid", ext_valid, m_busy);
         if (m_busy) begin
            chk("ext_address", ext_address, m_addr);
            chk("ext_write_data", ext_write_data, m_data);
            chk("ext_write_strobe", ext_write_strobe, m_strb);
            chk("ext_instruction", ext_instruction, (m_grant == 0));
         end
         chk("req_ready", req_ready, exp_ready);
         if (req_ready != '0) begin
            pulses++;
            for (int i = 0; i < N; i++) if (req_ready[i]) dlog.push_back(i);
            chk("req_read_data", req_read_data, ext_read_data);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int p0;
      reset            = 1'b0;
      req_valid        = '0;
      req_address      = '0;
      req_write_data   = '0;
      req_write_strobe = '0;
      ext_ready        = 1'b0;
      ext_read_data    = 32'h0;
      req_address[1*AW +: AW]    = 32'h200;
      req_address[2*AW +: AW]    = 32'h300;
      req_write_data[0*DW +: DW] = 32'h11111111;
      req_write_data[2*DW +: DW] = 32'h33333333;
      repeat (3) step();
      chk("reset_ext_valid", ext_valid, 0);
      reset = 1'b1;

      // Single instruction-fetch read.
      req_valid = 3'b001;
      req_address[0*AW +: AW] = 32'h100;
      p0 = pulses;
      step();
      chk("rd_valid", ext_valid, 1);
      chk("rd_instr", ext_instruction, 1);
      chk("rd_addr", ext_address, 32'h100);
      step();
      ext_ready = 1'b1;
      ext_read_data = 32'hDEADBEEF;
      #1;
      chk("rd_ready", req_ready, 3'b001);
      chk("rd_data", req_read_data, 32'hDEADBEEF);
      step();
      req_valid = '0;
      ext_ready = 1'b0;
      #1;
      chk("rd_ready_clear", req_ready, 0);
      chk("rd_pulses", pulses - p0, 1);

      // Store on channel 1 with three wait cycles.
      req_valid = 3'b010;
      req_write_data[1*DW +: DW]   = 32'h0000ABCD;
      req_write_strobe[1*SW +: SW] = 4'b0011;
      step();
      for (int w = 0; w < 4; w++) begin
         chk("st_strobe", ext_write_strobe, 4'b0011);
         chk("st_instr", ext_instruction, 0);
         chk("st_data", ext_write_data, 32'h0000ABCD);
         chk("st_addr", ext_address, 32'h200);
         if (w < 3) step();
      end
      ext_ready = 1'b1;
      step();
      req_valid = '0;
      ext_ready = 1'b0;
      req_write_strobe = '0;

      // Contention with all channels requesting continuously.
      reset = 1'b0;
      step();
      reset = 1'b1;
      mlog.delete();
      dlog.delete();
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
      exp_order = '{0, 1, 2, 0};
`else
      exp_order = '{0, 0, 0, 0};
`endif
      req_valid = 3'b111;
      ext_ready = 1'b1;
      repeat (8) step();
      req_valid = '0;
      ext_ready = 1'b0;
      step();
      chk("ct_dut_count", dlog.size(), 4);
      chk("ct_model_count", mlog.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < dlog.size()) chk("ct_dut_order", dlog[i], exp_order[i]);
         if (i < mlog.size()) chk("ct_model_order", mlog[i], exp_order[i]);
      end

      // Reset in BUSY after moving the pointer away from channel 0.
      req_valid = 3'b010;
      ext_ready = 1'b1;
      step();
      step();
      ext_ready = 1'b0;
      step();
      p0 = pulses;
      reset = 1'b0;
      #1;
      chk("abort_ext_valid", ext_valid, 0);
      chk("abort_req_ready", req_ready, 0);
      step();
      step();
      req_valid = 3'b111;
      reset = 1'b1;
      step();
      chk("post_rst_valid", ext_valid, 1);
      chk("post_rst_instr", ext_instruction, 1);
      ext_ready = 1'b1;
      #1;
      chk("post_rst_ready", req_ready, 3'b001);
      step();
      req_valid = '0;
      ext_ready = 1'b0;
      chk("abort_pulses", pulses - p0, 1);

      // Withdrawn request still completes; spurious ext_ready in IDLE ignored.
      p0 = pulses;
      req_valid = 3'b100;
      step();
      req_valid = '0;
      step();
      ext_ready = 1'b1;
      #1;
      chk("drop_ready", req_ready, 3'b100);
      chk("drop_addr", ext_address, 32'h300);
      step();
      chk("drop_pulses", pulses - p0, 1);
      p0 = pulses;
      repeat (3) step();
      chk("idle_ready", req_ready, 0);
      chk("idle_pulses", pulses - p0, 0);
      ext_ready = 1'b0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
